// File: rtl/uart_autobaud_if.sv
// Purpose: register-side bundle for the baud calibration block (requests, manual divisor, status).
// Latency: none; this is wiring only.
// Backpressure: none; requests are single-cycle strobes that the block may ignore while busy.
interface uart_autobaud_if;
    logic        cal_start;
    logic        cfg_wr;
    logic [12:0] cfg_div;
    logic [12:0] uart_ctrl;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_err;

    // Register interface side: issues requests, observes divisor and status.
    modport master (
        output cal_start, cfg_wr, cfg_div,
        input  uart_ctrl, cal_busy, cal_done, cal_err
    );

    // Calibration block side.
    modport slave (
        input  cal_start, cfg_wr, cfg_div,
        output uart_ctrl, cal_busy, cal_done, cal_err
    );
endinterface

// File: rtl/uart_autobaud.sv
// Purpose: measures a 0x55 sync char on rx and sets the 13-bit baud divisor; also holds a manual divisor.
// Latency: uart_ctrl/cal_done update 2 clocks after the final sync falling edge is seen (rx->edge 3 clocks).
// Backpressure: none; cal_start/cfg_wr are dropped while busy, cal_start beats cfg_wr in the same cycle.
// Optional: define UART_AUTOBAUD_GLITCH_CHK_EN to reject sync chars whose edge intervals disagree with the first.
module uart_autobaud #(
    parameter int unsigned          CNT_W       = 20,
    parameter logic [12:0]          DEFAULT_DIV = 13'd433,
    parameter logic [12:0]          MIN_DIV     = 13'd15,
    parameter logic [CNT_W-1:0]     TIMEOUT     = 20'd1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    uart_autobaud_if.slave  cfg
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_MEASURE, S_CALC, S_OK, S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, nstate;
    logic               rx_s1, rx_s2, rx_d;
    logic               fe;
    logic [CNT_W-1:0]   tmo_cnt, ival_cnt, tot_cnt;
    logic [CNT_W-1:0]   tmo_inc, ival_inc, tot_inc;
    logic [1:0]         ecnt;
    logic               tmo_hit, sat_hit, glitch;
    logic [CNT_W:0]     sum_w, q_w;
    logic               calc_bad;
    logic [12:0]        calc_div;
    logic [12:0]        uart_ctrl_q;
    logic               cal_err_q;
    logic               cal_busy_c, cal_done_c;

    // Two-flop synchronizer plus one delay stage for falling-edge detection; idle line is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fe = rx_d & ~rx_s2;

    // Saturating increments; a counter stuck at max aborts the calibration.
    assign tmo_inc  = (tmo_cnt  == CNT_MAX) ? CNT_MAX : tmo_cnt  + 1'b1;
    assign ival_inc = (ival_cnt == CNT_MAX) ? CNT_MAX : ival_cnt + 1'b1;
    assign tot_inc  = (tot_cnt  == CNT_MAX) ? CNT_MAX : tot_cnt  + 1'b1;
    assign tmo_hit  = !fe && (tmo_cnt >= TIMEOUT - 1'b1);
    assign sat_hit  = (ival_cnt == CNT_MAX) || (tot_cnt == CNT_MAX);

    // In CALC tot_cnt holds the 8-bit-period total; round to one bit period and range-check.
    // The extra top bit of sum_w flags an overflowed +4, which is treated as a failure.
    assign sum_w    = {1'b0, tot_cnt} + (CNT_W+1)'(4);
    assign q_w      = sum_w >> 3;
    assign calc_bad = sum_w[CNT_W] || (q_w > (CNT_W+1)'(8192)) || (q_w <= (CNT_W+1)'(MIN_DIV));
    assign calc_div = q_w[12:0] - 13'd1;

`ifdef UART_AUTOBAUD_GLITCH_CHK_EN
    logic [CNT_W-1:0] i1_q;
    logic [CNT_W-1:0] ik_diff;

    // The first interval is counted from a cleared counter, so the edge cycle is added back (ival_inc);
    // later intervals restart at 1 and are complete as-is.
    always_comb begin
        glitch  = 1'b0;
        ik_diff = (ival_cnt > i1_q) ? (ival_cnt - i1_q) : (i1_q - ival_cnt);
        if (state == S_MEASURE && fe) begin
            if (ecnt == 2'd0)
                glitch = (ival_inc < CNT_W'(4));
            else
                glitch = (ik_diff > (i1_q >> 2));
        end
    end

    // Capture the first edge-to-edge interval as the reference for the rest.
    always_ff @(posedge clk) begin
        if (rst)
            i1_q <= '0;
        else if (state == S_MEASURE && fe && ecnt == 2'd0)
            i1_q <= ival_inc;
    end
`else
    assign glitch = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= nstate;
    end

    // FSM next-state logic.
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE: begin
                if (cfg.cal_start)
                    nstate = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (fe)
                    nstate = S_MEASURE;
                else if (tmo_hit)
                    nstate = S_FAIL;
            end
            S_MEASURE: begin
                if (glitch || sat_hit)
                    nstate = S_FAIL;
                else if (fe && ecnt == 2'd3)
                    nstate = S_CALC;
                else if (tmo_hit)
                    nstate = S_FAIL;
            end
            S_CALC:  nstate = calc_bad ? S_FAIL : S_OK;
            S_OK:    nstate = S_IDLE;
            S_FAIL:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        cal_busy_c = 1'b0;
        cal_done_c = 1'b0;
        case (state)
            S_WAIT_START, S_MEASURE, S_CALC: cal_busy_c = 1'b1;
            S_OK, S_FAIL:                    cal_done_c = 1'b1;
            default: ;
        endcase
    end

    // Timeout, interval, total and edge counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            ival_cnt <= '0;
            tot_cnt  <= '0;
            ecnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg.cal_start)
                        tmo_cnt <= '0;
                end
                S_WAIT_START: begin
                    tmo_cnt <= fe ? '0 : tmo_inc;
                    if (fe) begin
                        ival_cnt <= '0;
                        tot_cnt  <= '0;
                        ecnt     <= '0;
                    end
                end
                S_MEASURE: begin
                    tot_cnt <= tot_inc;
                    if (fe) begin
                        tmo_cnt  <= '0;
                        ival_cnt <= CNT_W'(1);
                        ecnt     <= ecnt + 2'd1;
                    end else begin
                        tmo_cnt  <= tmo_inc;
                        ival_cnt <= ival_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Divisor and error level; updated on entry to OK/FAIL so they line up with cal_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_ctrl_q <= DEFAULT_DIV;
            cal_err_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && cfg.cal_start)
                cal_err_q <= 1'b0;
            else if (state == S_IDLE && cfg.cfg_wr)
                uart_ctrl_q <= cfg.cfg_div;

            if (nstate == S_OK) begin
                uart_ctrl_q <= calc_div;
                cal_err_q   <= 1'b0;
            end else if (nstate == S_FAIL) begin
                cal_err_q   <= 1'b1;
            end
        end
    end

    assign cfg.uart_ctrl = uart_ctrl_q;
    assign cfg.cal_busy  = cal_busy_c;
    assign cfg.cal_done  = cal_done_c;
    assign cfg.cal_err   = cal_err_q;

endmodule
